// File: rtl/sim_ahb_arb2.sv
// Two-port AHB-Lite arbiter in front of the sim-control slave.
// Round-robin on contention; a losing address phase is parked in pend[] and its master is stalled.
module sim_ahb_arb2 #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    output logic              src0_hready_resp,
    input  logic              src0_hready,
    output logic              src0_hresp,
    input  logic [W_ADDR-1:0] src0_haddr,
    input  logic              src0_hwrite,
    input  logic [1:0]        src0_htrans,
    input  logic [2:0]        src0_hsize,
    input  logic [2:0]        src0_hburst,
    input  logic [3:0]        src0_hprot,
    input  logic              src0_hmastlock,
    input  logic [W_DATA-1:0] src0_hwdata,
    output logic [W_DATA-1:0] src0_hrdata,

    output logic              src1_hready_resp,
    input  logic              src1_hready,
    output logic              src1_hresp,
    input  logic [W_ADDR-1:0] src1_haddr,
    input  logic              src1_hwrite,
    input  logic [1:0]        src1_htrans,
    input  logic [2:0]        src1_hsize,
    input  logic [2:0]        src1_hburst,
    input  logic [3:0]        src1_hprot,
    input  logic              src1_hmastlock,
    input  logic [W_DATA-1:0] src1_hwdata,
    output logic [W_DATA-1:0] src1_hrdata,

    output logic              dst_hready,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata
);

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic              write;
        logic [1:0]        trans;
        logic [2:0]        size;
        logic [2:0]        burst;
        logic [3:0]        prot;
        logic              mastlock;
    } aph_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } own_t;

    aph_t       live [2];
    aph_t       pend [2];
    logic [1:0] pend_v;
    own_t       dph_own;
    logic       last_gnt;
    logic [1:0] live_req;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       win;
    aph_t       sel;

    assign live[0] = '{addr: src0_haddr, write: src0_hwrite, trans: src0_htrans,
                       size: src0_hsize, burst: src0_hburst, prot: src0_hprot,
                       mastlock: src0_hmastlock};
    assign live[1] = '{addr: src1_haddr, write: src1_hwrite, trans: src1_htrans,
                       size: src1_hsize, burst: src1_hburst, prot: src1_hprot,
                       mastlock: src1_hmastlock};

    // Arbitration and address mux; reset also suppresses any live request reaching the slave.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        win      = 1'b0;
        gnt      = 2'b00;
        live_req = {src1_htrans[1] & src1_hready, src0_htrans[1] & src0_hready};
        req      = pend_v | live_req;
        if (rst_n && dst_hready_resp) begin
            case (req)
                2'b01:   win = 1'b0;
                2'b10:   win = 1'b1;
                2'b11:   win = ~last_gnt;
                default: win = 1'b0;
            endcase
            if (req != 2'b00) gnt = win ? 2'b10 : 2'b01;
        end
        sel = pend_v[win] ? pend[win] : live[win];
        if (gnt == 2'b00) sel = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v   <= 2'b00;
            dph_own  <= OWN_NONE;
            last_gnt <= 1'b1;
        end else begin
            // NOTE: state registers use non-blocking assignment so every branch sees pre-edge values.
            for (int i = 0; i < 2; i++) begin
                if (gnt[i])           pend_v[i] <= 1'b0;
                else if (live_req[i]) pend_v[i] <= 1'b1;
            end
            if (dst_hready_resp) begin
                if (gnt != 2'b00) begin
                    last_gnt <= win;
                    dph_own  <= win ? OWN_1 : OWN_0;
                end else begin
                    dph_own  <= OWN_NONE;
                end
            end
        end
    end

    // NOTE: the parked payload is only ever read while pend_v is set, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!pend_v[i] && !gnt[i] && live_req[i]) pend[i] <= live[i];
        end
    end

    assign dst_haddr     = sel.addr;
    assign dst_hwrite    = sel.write;
    assign dst_htrans    = sel.trans;
    assign dst_hsize     = sel.size;
    assign dst_hburst    = sel.burst;
    assign dst_hprot     = sel.prot;
    assign dst_hmastlock = sel.mastlock;
    assign dst_hready    = dst_hready_resp;

    assign src0_hready_resp = (dph_own == OWN_0) ? dst_hready_resp : ~pend_v[0];
    assign src1_hready_resp = (dph_own == OWN_1) ? dst_hready_resp : ~pend_v[1];
    assign src0_hresp       = (dph_own == OWN_0) & dst_hresp;
    assign src1_hresp       = (dph_own == OWN_1) & dst_hresp;
    assign src0_hrdata      = dst_hrdata;
    assign src1_hrdata      = dst_hrdata;

    always_comb begin
        case (dph_own)
            OWN_0:   dst_hwdata = src0_hwdata;
            OWN_1:   dst_hwdata = src1_hwdata;
            default: dst_hwdata = '0;
        endcase
    end

endmodule
